frame_feeder: RTL and testbench

- Store-and-forward stage directly upstream of the length-programmed accumulator (dut).
- Collects one byte frame delimited by a last flag, then drives the accumulator's len method with the frame length, followed by exactly that many bytes on its din method.
- Guarantees len_en and din_en are never high in the same cycle.
- Handshakes are method-style: en is asserted only while the matching rdy is high; a transfer occurs in every cycle en is high.

---
 rtl/frame_feeder.sv | 163 ++++++++++++++++
 tb/tb_frame_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_feeder.sv
// frame_feeder: store-and-forward stage feeding a length-programmed accumulator.
// Buffers one byte frame (terminated by in_last), then issues the frame length
// on the len method followed by exactly that many bytes on the din method.
// Frames longer than DEPTH are cut at DEPTH bytes; the tail is dropped and
// trunc_flag is set (sticky until reset).
//
// Optional feature macro: FRAME_FEEDER_STATS_EN adds frames_sent/bytes_sent.
//
// Ports:
//   CLK, RST_N            clock, async active-low reset
//   in_value/in_last/in_en/in_rdy     upstream byte write (method style)
//   len_value/len_en/len_rdy          frame length toward the accumulator
//   din_value/din_en/din_rdy          frame bytes toward the accumulator
//   trunc_flag            sticky truncation indicator
//   frames_sent, bytes_sent (FRAME_FEEDER_STATS_EN only) wrapping counters
module frame_feeder #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [7:0]  in_value,
   input  logic        in_last,
   input  logic        in_en,
   output logic        in_rdy,
   output logic [7:0]  len_value,
   output logic        len_en,
   input  logic        len_rdy,
   output logic [7:0]  din_value,
   output logic        din_en,
   input  logic        din_rdy,
   output logic        trunc_flag
`ifdef FRAME_FEEDER_STATS_EN
   ,
   output logic [15:0] frames_sent,
   output logic [15:0] bytes_sent
`endif
);

   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      COLLECT   = 2'd0,
      DRAIN     = 2'd1,
      SEND_LEN  = 2'd2,
      SEND_DATA = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   wr_cnt, wr_cnt_nxt;
   logic [CW-1:0]   rd_ptr, rd_ptr_nxt;
   logic [7:0]      frame_len, frame_len_nxt;
   logic            trunc_nxt;
   logic            buf_we;
   logic [7:0]      buf_mem [2**AW];

   // Frame buffer storage; contents are intentionally not reset.
   always_ff @(posedge CLK) begin
      if (buf_we) begin
         buf_mem[AW'(wr_cnt)] <= in_value;
      end
   end

   // State and counter registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= COLLECT;
         wr_cnt     <= '0;
         rd_ptr     <= '0;
         frame_len  <= '0;
         trunc_flag <= 1'b0;
      end else begin
         state      <= state_nxt;
         wr_cnt     <= wr_cnt_nxt;
         rd_ptr     <= rd_ptr_nxt;
         frame_len  <= frame_len_nxt;
         trunc_flag <= trunc_nxt;
      end
   end

   // Next-state and method strobes; len_en/din_en follow rdy only in their
   // own state, so they can never be high together.
   always_comb begin
      state_nxt     = state;
      wr_cnt_nxt    = wr_cnt;
      rd_ptr_nxt    = rd_ptr;
      frame_len_nxt = frame_len;
      trunc_nxt     = trunc_flag;
      buf_we        = 1'b0;
      in_rdy        = 1'b0;
      len_en        = 1'b0;
      din_en        = 1'b0;
      len_value     = 8'd0;
      din_value     = 8'd0;

      case (state)
         COLLECT: begin
            in_rdy = 1'b1;
            if (in_en) begin
               buf_we     = 1'b1;
               wr_cnt_nxt = wr_cnt + CW'(1);
               if (in_last || (wr_cnt_nxt == CW'(DEPTH))) begin
                  frame_len_nxt = 8'(wr_cnt_nxt);
                  if (in_last) begin
                     state_nxt = SEND_LEN;
                  end else begin
                     // Buffer full before the end of frame: drop the tail.
                     trunc_nxt = 1'b1;
                     state_nxt = DRAIN;
                  end
               end
            end
         end
         DRAIN: begin
            in_rdy = 1'b1;
            if (in_en && in_last) begin
               state_nxt = SEND_LEN;
            end
         end
         SEND_LEN: begin
            len_value = frame_len;
            len_en    = len_rdy;
            if (len_rdy) begin
               rd_ptr_nxt = '0;
               state_nxt  = SEND_DATA;
            end
         end
         SEND_DATA: begin
            din_value = buf_mem[AW'(rd_ptr)];
            din_en    = din_rdy;
            if (din_rdy) begin
               rd_ptr_nxt = rd_ptr + CW'(1);
               if (rd_ptr == CW'(frame_len - 8'd1)) begin
                  wr_cnt_nxt = '0;
                  state_nxt  = COLLECT;
               end
            end
         end
         default: begin
            state_nxt = COLLECT;
         end
      endcase
   end

`ifdef FRAME_FEEDER_STATS_EN
   // Wrapping transfer statistics; the final byte of a frame is the only
   // din transfer that returns the FSM to COLLECT.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         frames_sent <= 16'd0;
         bytes_sent  <= 16'd0;
      end else begin
         if (din_en) begin
            bytes_sent <= bytes_sent + 16'd1;
            if (state_nxt == COLLECT) begin
               frames_sent <= frames_sent + 16'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_frame_feeder.sv
// Self-checking bench for frame_feeder: scoreboard queues of expected lengths
// and bytes are filled when a frame is driven and drained by a monitor.
module tb_frame_feeder;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;

   logic        CLK;
   logic        RST_N;
   logic [7:0]  in_value;
   logic        in_last;
   logic        in_en;
   logic        in_rdy;
   logic [7:0]  len_value;
   logic        len_en;
   logic        len_rdy;
   logic [7:0]  din_value;
   logic        din_en;
   logic        din_rdy;
   logic        trunc_flag;
`ifdef FRAME_FEEDER_STATS_EN
   logic [15:0] frames_sent;
   logic [15:0] bytes_sent;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  exp_len [$];
   logic [7:0]  exp_din [$];
   int          exp_frames;
   int          exp_bytes;
   bit          rand_rdy;
   logic [7:0]  frm [32];

   frame_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .in_value   (in_value),
      .in_last    (in_last),
      .in_en      (in_en),
      .in_rdy     (in_rdy),
      .len_value  (len_value),
      .len_en     (len_en),
      .len_rdy    (len_rdy),
      .din_value  (din_value),
      .din_en     (din_en),
      .din_rdy    (din_rdy),
      .trunc_flag (trunc_flag)
`ifdef FRAME_FEEDER_STATS_EN
      ,
      .frames_sent(frames_sent),
      .bytes_sent (bytes_sent)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      if (rand_rdy) begin
         len_rdy = 1'($urandom_range(0, 1));
         din_rdy = 1'($urandom_range(0, 1));
      end
   endtask

   // Push the expected result of frm[0..n-1], then write the bytes upstream.
   task automatic send_frame(input int n);
      int kept;
      kept = (n > int'(DEPTH)) ? int'(DEPTH) : n;
      exp_len.push_back(8'(kept));
      for (int i = 0; i < kept; i++) exp_din.push_back(frm[i]);
      exp_frames++;
      exp_bytes += kept;
      for (int i = 0; i < n; i++) begin
         int w = 0;
         while (!in_rdy && w < 3000) begin
            tick();
            w++;
         end
         if (w >= 3000) chk("in_rdy_wait", 32'(in_rdy), 32'd1);
         in_value = frm[i];
         in_last  = (i == n - 1);
         in_en    = 1'b1;
         tick();
         in_en    = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int w = 0;
      while (!(in_rdy && exp_len.size() == 0 && exp_din.size() == 0) && w < 3000) begin
         tick();
         w++;
      end
      chk("idle_wait", 32'(w < 3000), 32'd1);
   endtask

   // Output monitor: scoreboard pops and the len/din exclusion check.
   always @(negedge CLK) begin
      if (RST_N) begin
         if (len_en || din_en) chk("len_din_excl", 32'(len_en && din_en), 32'd0);
         if (len_en) begin
            chk("len_expected", 32'(exp_len.size() != 0), 32'd1);
            if (exp_len.size() != 0) chk("len_value", 32'(len_value), 32'(exp_len.pop_front()));
         end
         if (din_en) begin
            chk("din_expected", 32'(exp_din.size() != 0), 32'd1);
            if (exp_din.size() != 0) chk("din_value", 32'(din_value), 32'(exp_din.pop_front()));
         end
      end
   end

   initial begin
      RST_N      = 1'b1;
      in_en      = 1'b0;
      in_last    = 1'b0;
      in_value   = 8'd0;
      len_rdy    = 1'b1;
      din_rdy    = 1'b1;
      rand_rdy   = 1'b0;
      exp_frames = 0;
      exp_bytes  = 0;

      // Reset values
      #1 RST_N = 1'b0;
      #2;
      chk("rst_in_rdy",     32'(in_rdy),     32'd1);
      chk("rst_len_en",     32'(len_en),     32'd0);
      chk("rst_din_en",     32'(din_en),     32'd0);
      chk("rst_len_value",  32'(len_value),  32'd0);
      chk("rst_din_value",  32'(din_value),  32'd0);
      chk("rst_trunc_flag", 32'(trunc_flag), 32'd0);
`ifdef FRAME_FEEDER_STATS_EN
      chk("rst_frames_sent", 32'(frames_sent), 32'd0);
      chk("rst_bytes_sent",  32'(bytes_sent),  32'd0);
`endif
      repeat (2) tick();
      RST_N = 1'b1;
      tick();

      // Basic 3-byte frame with exact latency
      frm[0] = 8'h11; frm[1] = 8'h22; frm[2] = 8'h33;
      send_frame(3);
      chk("basic_len_en_t1",    32'(len_en),    32'd1);
      chk("basic_len_value_t1", 32'(len_value), 32'd3);
      chk("basic_din_en_t1",    32'(din_en),    32'd0);
      tick();
      chk("basic_din_en_t2",    32'(din_en),    32'd1);
      chk("basic_din0",         32'(din_value), 32'h11);
      chk("basic_len_once",     32'(len_en),    32'd0);
      tick();
      chk("basic_din1",         32'(din_value), 32'h22);
      tick();
      chk("basic_din2",         32'(din_value), 32'h33);
      tick();
      chk("basic_in_rdy_back",  32'(in_rdy),    32'd1);
      chk("basic_din_en_done",  32'(din_en),    32'd0);
      wait_idle();

      // Single-byte frame
      frm[0] = 8'hA5;
      send_frame(1);
      chk("single_len_value", 32'(len_value), 32'd1);
      tick();
      chk("single_din_en",    32'(din_en),    32'd1);
      chk("single_din_value", 32'(din_value), 32'hA5);
      tick();
      chk("single_in_rdy",    32'(in_rdy),    32'd1);
      wait_idle();

      // len backpressure for 5 cycles
      len_rdy = 1'b0;
      frm[0] = 8'h01; frm[1] = 8'h02; frm[2] = 8'h03;
      send_frame(3);
      for (int k = 0; k < 5; k++) begin
         chk("lbp_len_en",    32'(len_en),    32'd0);
         chk("lbp_len_value", 32'(len_value), 32'd3);
         chk("lbp_din_en",    32'(din_en),    32'd0);
         tick();
      end
      len_rdy = 1'b1;
      wait_idle();

      // din_rdy toggling
      frm[0] = 8'h41; frm[1] = 8'h42; frm[2] = 8'h43; frm[3] = 8'h44;
      send_frame(4);
      for (int i = 0; i < 8; i++) begin
         din_rdy = (i % 2 == 0);
         #1;
         if (i % 2 == 1) begin
            chk("dbp_din_en", 32'(din_en), 32'd0);
            if (exp_din.size() != 0) chk("dbp_din_hold", 32'(din_value), 32'(exp_din[0]));
         end
         tick();
      end
      din_rdy = 1'b1;
      wait_idle();

      // Truncation at DEPTH bytes
      chk("trunc_before", 32'(trunc_flag), 32'd0);
      for (int i = 0; i < 20; i++) frm[i] = 8'(i);
      send_frame(20);
      chk("trunc_len_value", 32'(len_value), 32'(DEPTH));
      wait_idle();
      chk("trunc_set", 32'(trunc_flag), 32'd1);
      frm[0] = 8'h61; frm[1] = 8'h62;
      send_frame(2);
      wait_idle();
      chk("trunc_sticky", 32'(trunc_flag), 32'd1);

      // Reset after the 2nd din transfer of a 4-byte frame
      frm[0] = 8'h51; frm[1] = 8'h52; frm[2] = 8'h53; frm[3] = 8'h54;
      send_frame(4);
      repeat (3) tick();
      RST_N = 1'b0;
      #1;
      chk("mrst_in_rdy",     32'(in_rdy),     32'd1);
      chk("mrst_len_en",     32'(len_en),     32'd0);
      chk("mrst_din_en",     32'(din_en),     32'd0);
      chk("mrst_len_value",  32'(len_value),  32'd0);
      chk("mrst_din_value",  32'(din_value),  32'd0);
      chk("mrst_trunc_flag", 32'(trunc_flag), 32'd0);
      chk("mrst_left",       32'(exp_din.size()), 32'd2);
      exp_din.delete();
      exp_len.delete();
      exp_frames = 0;
      exp_bytes  = 0;
`ifdef FRAME_FEEDER_STATS_EN
      chk("mrst_frames_sent", 32'(frames_sent), 32'd0);
      chk("mrst_bytes_sent",  32'(bytes_sent),  32'd0);
`endif
      repeat (2) tick();
      RST_N = 1'b1;
      tick();
      frm[0] = 8'h7E;
      send_frame(1);
      chk("post_rst_len_value", 32'(len_value), 32'd1);
      tick();
      chk("post_rst_din_value", 32'(din_value), 32'h7E);
      wait_idle();

      // Random ready patterns over 200 frames
      rand_rdy = 1'b1;
      for (int f = 0; f < 200; f++) begin
         int n;
         n = int'($urandom_range(1, 20));
         for (int i = 0; i < n; i++) frm[i] = 8'($urandom_range(0, 255));
         send_frame(n);
      end
      wait_idle();
      rand_rdy = 1'b0;
      len_rdy  = 1'b1;
      din_rdy  = 1'b1;
`ifdef FRAME_FEEDER_STATS_EN
      chk("stats_frames_sent", 32'(frames_sent), 32'(16'(exp_frames)));
      chk("stats_bytes_sent",  32'(bytes_sent),  32'(16'(exp_bytes)));
`endif
      chk("final_trunc_flag", 32'(trunc_flag), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
